// File: rtl/crtc.sv
// 6845-style CRT controller for the Colour Genie video path: character/raster
// timing, refresh addressing, sync, display enable and cursor, Z80-programmable.
module crtc #(
  parameter int HSW0 = 16,
  parameter int VSW0 = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cce,
  input  logic        cs,
  input  logic        rs,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [13:0] ma,
  output logic [4:0]  ra,
  output logic        cursor
);

  logic [7:0]  r0, r1, r2, r3;
  logic [6:0]  r4, r6, r7, r10;
  logic [4:0]  r5, r9, r11;
  logic [5:0]  r12, r14;
  logic [7:0]  r13, r15;
  logic [4:0]  index;

  logic [7:0]  hCount;
  logic [6:0]  row;
  logic [4:0]  raCount;
  logic [4:0]  adjCount;
  logic        inAdj;
  logic [4:0]  hsWidth;
  logic [4:0]  vsWidth;
  logic [4:0]  field;
  logic [13:0] lineStart;

  // A programmed width of zero selects the default width.
  function automatic logic [4:0] syncWidth(input logic [3:0] prog, input logic [4:0] dflt);
    return (prog == 4'd0) ? dflt : {1'b0, prog};
  endfunction

  logic        lineEnd_p0, scanEnd_p0, lastRow_p0, adjEnd_p0, frameEnd_p0;
  logic        hsStart_p0, vsStart_p0;
  logic [4:0]  hsLen_p0, vsLen_p0;
  logic        hde_p0, vde_p0, de_p0, hsync_p0, vsync_p0;
  logic        blink_p0, curRows_p0, cursor_p0;
  logic [13:0] ma_p0;

  // p0: decode the current character cell from the counters
  always_comb begin
    lineEnd_p0  = (hCount == r0);
    scanEnd_p0  = (raCount == r9);
    lastRow_p0  = (row == r4);
    adjEnd_p0   = inAdj && (adjCount == (r5 - 5'd1));
    frameEnd_p0 = adjEnd_p0 || (!inAdj && scanEnd_p0 && lastRow_p0 && (r5 == 5'd0));

    hsLen_p0    = syncWidth(r3[3:0], 5'(HSW0));
    vsLen_p0    = syncWidth(r3[7:4], 5'(VSW0));
    hsStart_p0  = (hCount == r2);
    vsStart_p0  = (row == r7) && (raCount == 5'd0) && !inAdj;
    hsync_p0    = hsStart_p0 || (hsWidth != 5'd0);
    vsync_p0    = vsStart_p0 || (vsWidth != 5'd0);

    hde_p0      = (hCount < r1);
    vde_p0      = (row < r6) && !inAdj;
    de_p0       = hde_p0 && vde_p0;
    ma_p0       = lineStart + {6'd0, hCount};

    blink_p0 = 1'b1;
    case (r10[6:5])
      2'b00:   blink_p0 = 1'b1;
      2'b01:   blink_p0 = 1'b0;
      2'b10:   blink_p0 = field[3];
      default: blink_p0 = field[4];
    endcase
    curRows_p0 = (raCount >= r10[4:0]) && (raCount <= r11);
    cursor_p0  = de_p0 && (ma_p0 == {r14, r15}) && curRows_p0 && blink_p0;
  end

  // CPU register file; writes are level-sensitive and ignore cce
  always_ff @(posedge clock) begin
    if (!reset) begin
      index <= '0;
      r0  <= '0; r1  <= '0; r2  <= '0; r3  <= '0;
      r4  <= '0; r5  <= '0; r6  <= '0; r7  <= '0;
      r9  <= '0; r10 <= '0; r11 <= '0;
      r12 <= '0; r13 <= '0; r14 <= '0; r15 <= '0;
    end else if (!cs && !wr) begin
      if (!rs) begin
        index <= d[4:0];
      end else begin
        case (index)
          5'd0:  r0  <= d;
          5'd1:  r1  <= d;
          5'd2:  r2  <= d;
          5'd3:  r3  <= d;
          5'd4:  r4  <= d[6:0];
          5'd5:  r5  <= d[4:0];
          5'd6:  r6  <= d[6:0];
          5'd7:  r7  <= d[6:0];
          5'd9:  r9  <= d[4:0];
          5'd10: r10 <= d[6:0];
          5'd11: r11 <= d[4:0];
          5'd12: r12 <= d[5:0];
          5'd13: r13 <= d;
          5'd14: r14 <= d[5:0];
          5'd15: r15 <= d;
          default: ;
        endcase
      end
    end
  end

  // Only the cursor address is readable; everything else reads as zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (!cs && !rd && rs && (index == 5'd14)) begin
      q <= {2'b00, r14};
    end else if (!cs && !rd && rs && (index == 5'd15)) begin
      q <= r15;
    end else begin
      q <= '0;
    end
  end

  // p0 -> next state: advance the timing counters on each character tick
  always_ff @(posedge clock) begin
    if (!reset) begin
      hCount    <= '0;
      row       <= '0;
      raCount   <= '0;
      adjCount  <= '0;
      inAdj     <= 1'b0;
      hsWidth   <= '0;
      vsWidth   <= '0;
      field     <= '0;
      lineStart <= '0;
    end else if (cce) begin
      hCount  <= lineEnd_p0 ? 8'd0 : hCount + 8'd1;
      hsWidth <= hsStart_p0 ? hsLen_p0 - 5'd1
               : (hsWidth != 5'd0) ? hsWidth - 5'd1 : 5'd0;
      if (lineEnd_p0) begin
        vsWidth <= vsStart_p0 ? vsLen_p0 - 5'd1
                 : (vsWidth != 5'd0) ? vsWidth - 5'd1 : 5'd0;
        if (frameEnd_p0) begin
          row       <= '0;
          raCount   <= '0;
          adjCount  <= '0;
          inAdj     <= 1'b0;
          field     <= field + 5'd1;
          lineStart <= {r12, r13};
        end else if (inAdj) begin
          adjCount <= adjCount + 5'd1;
          raCount  <= raCount + 5'd1;
        end else if (scanEnd_p0) begin
          raCount   <= '0;
          lineStart <= lineStart + {6'd0, r1};
          if (lastRow_p0) begin
            inAdj    <= 1'b1;
            adjCount <= '0;
          end else begin
            row <= row + 7'd1;
          end
        end else begin
          raCount <= raCount + 5'd1;
        end
      end
    end
  end

  // p1: registered outputs, all describing the same character cell
  always_ff @(posedge clock) begin
    if (!reset) begin
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      de     <= 1'b0;
      ma     <= '0;
      ra     <= '0;
      cursor <= 1'b0;
    end else if (cce) begin
      hsync  <= hsync_p0;
      vsync  <= vsync_p0;
      de     <= de_p0;
      ma     <= ma_p0;
      ra     <= raCount;
      cursor <= cursor_p0;
    end
  end

endmodule
